// File: rtl/vram_arbiter.sv
// Framebuffer RAM arbiter: VGA scan-out reads take priority on each pixel tick,
// drawing-engine writes are queued in a small FIFO and issued in free cycles.
module vram_arbiter #(
   parameter int FB_W     = 160,
   parameter int FB_H     = 120,
   parameter int SCALE_SH = 2,
   parameter int ADDR_W   = 15,
   parameter int PIX_W    = 12,
   parameter int FIFO_D   = 4
) (
   input  logic              clk_in,
   input  logic              reset,
   input  logic              pix_tick,
   input  logic              active_video,
   input  logic [9:0]        x,
   input  logic [9:0]        y,
   input  logic              wr_valid,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [PIX_W-1:0]  wr_data,
   output logic              wr_ready,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_we,
   output logic [PIX_W-1:0]  ram_wdata,
   input  logic [PIX_W-1:0]  ram_rdata,
   output logic [3:0]        red,
   output logic [3:0]        green,
   output logic [3:0]        blue,
   output logic [7:0]        err_cnt
);

   localparam int PTR_W = $clog2(FIFO_D);
   localparam logic [ADDR_W-1:0] FB_W_A    = ADDR_W'(FB_W);
   localparam logic [ADDR_W-1:0] FB_SIZE_A = ADDR_W'(FB_W * FB_H);
   localparam logic [PTR_W:0]    FULL_CNT  = (PTR_W + 1)'(FIFO_D);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RD_ADDR = 2'd1,
      RD_DATA = 2'd2
   } state_t;

   state_t            state_r;
   logic [ADDR_W-1:0] fifo_addr_r [FIFO_D];
   logic [PIX_W-1:0]  fifo_data_r [FIFO_D];
   logic [PTR_W-1:0]  wptr_r;
   logic [PTR_W-1:0]  rptr_r;
   logic [PTR_W:0]    count_r;
   logic [ADDR_W-1:0] rd_addr_r;
   logic              rd_pend_r;

   logic              rd_req_s;
   logic              full_s;
   logic              push_s;
   logic              pop_s;
   logic              head_ok_s;
   logic [ADDR_W-1:0] pix_addr_s;

   assign rd_req_s   = pix_tick & active_video;
   assign full_s     = (count_r == FULL_CNT);
   assign wr_ready   = ~full_s;
   assign push_s     = wr_valid & ~full_s;
   // A write slot exists only when the FSM is idle and no scan-out read claims this edge.
   assign pop_s      = (state_r == IDLE) & ~rd_req_s & (count_r != '0);
   assign head_ok_s  = (fifo_addr_r[rptr_r] < FB_SIZE_A);
   assign pix_addr_s = ADDR_W'(y >> SCALE_SH) * FB_W_A + ADDR_W'(x >> SCALE_SH);

   // Write FIFO storage (no reset needed, validity tracked by count_r).
   always_ff @(posedge clk_in) begin
      if (push_s) begin
         fifo_addr_r[wptr_r] <= wr_addr;
         fifo_data_r[wptr_r] <= wr_data;
      end
   end

   // Write FIFO pointers and occupancy.
   always_ff @(posedge clk_in or negedge reset) begin
      if (!reset) begin
         wptr_r  <= '0;
         rptr_r  <= '0;
         count_r <= '0;
      end else begin
         if (push_s) begin
            wptr_r <= wptr_r + 1'b1;
         end
         if (pop_s) begin
            rptr_r <= rptr_r + 1'b1;
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + 1'b1;
            2'b01:   count_r <= count_r - 1'b1;
            default: count_r <= count_r;
         endcase
      end
   end

   // Arbitration FSM with registered RAM command, colour and error outputs.
   always_ff @(posedge clk_in or negedge reset) begin
      if (!reset) begin
         state_r   <= IDLE;
         rd_addr_r <= '0;
         rd_pend_r <= 1'b0;
         ram_addr  <= '0;
         ram_we    <= 1'b0;
         ram_wdata <= '0;
         red       <= 4'd0;
         green     <= 4'd0;
         blue      <= 4'd0;
         err_cnt   <= 8'd0;
      end else begin
         ram_we    <= 1'b0;
         rd_pend_r <= 1'b0;
         // RAM data for the read issued two edges ago is valid now.
         if (rd_pend_r) begin
            {red, green, blue} <= ram_rdata;
         end
         case (state_r)
            IDLE: begin
               if (rd_req_s) begin
                  state_r   <= RD_ADDR;
                  rd_addr_r <= pix_addr_s;
               end else begin
                  if (pix_tick) begin
                     red   <= 4'd0;
                     green <= 4'd0;
                     blue  <= 4'd0;
                  end
                  if (pop_s) begin
                     if (head_ok_s) begin
                        ram_addr  <= fifo_addr_r[rptr_r];
                        ram_wdata <= fifo_data_r[rptr_r];
                        ram_we    <= 1'b1;
                     end else if (err_cnt != 8'hFF) begin
                        err_cnt <= err_cnt + 8'd1;
                     end
                  end
               end
            end
            RD_ADDR: begin
               ram_addr <= rd_addr_r;
               state_r  <= RD_DATA;
            end
            RD_DATA: begin
               rd_pend_r <= 1'b1;
               state_r   <= IDLE;
            end
            default: begin
               state_r <= IDLE;
            end
         endcase
      end
   end

endmodule
